// File: rtl/dqpsk_diff_decode.sv
// Receive-side differential QPSK decoder: recovers data dibits from the phase step
// between consecutive Gray-coded symbols and serializes them MSB-first.
//
// state | meaning
// ACQ   | no reference phase; the next accepted symbol becomes the reference
// RUN   | locked; each accepted symbol is decoded against the previous one
module dqpsk_diff_decode #(
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       resync,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic       sym_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       locked
);

  typedef enum logic {ACQ = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(IDLE_TIMEOUT);
  localparam bit               TMO_EN = (IDLE_TIMEOUT != 0);

  state_t           state;
  logic             started;
  logic             ser_lsb;
  logic             lsb_q;
  logic [1:0]       prev;
  logic [CNT_W-1:0] idle_cnt;

  logic       accept;
  logic       msb_phase;
  logic       lsb_phase;
  logic       timeout;
  logic [1:0] cur;
  logic [1:0] dibit;

  function automatic logic [1:0] gray2phase(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  function automatic logic [1:0] phase2gray(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  assign msb_phase = bit_valid & ~ser_lsb;
  assign lsb_phase = bit_valid & ser_lsb;

  // started keeps ready low until the first edge after reset release
  assign sym_ready = started & ((state == ACQ) | resync | ~bit_valid | ser_lsb);
  assign accept    = sym_valid & sym_ready;
  assign locked    = (state == RUN);

  assign cur     = gray2phase(sym_in);
  assign dibit   = phase2gray(cur - prev);
  assign timeout = TMO_EN && (idle_cnt == TMO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACQ;
      started   <= 1'b0;
      ser_lsb   <= 1'b0;
      lsb_q     <= 1'b0;
      prev      <= 2'b00;
      idle_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      started <= 1'b1;
      if (resync) begin
        // pending LSB is dropped; a coincident symbol becomes the new reference
        bit_valid <= 1'b0;
        ser_lsb   <= 1'b0;
        idle_cnt  <= '0;
        if (accept) begin
          prev  <= cur;
          state <= RUN;
        end else begin
          state <= ACQ;
        end
      end else begin
        case (state)
          ACQ: begin
            idle_cnt  <= '0;
            bit_valid <= 1'b0;
            ser_lsb   <= 1'b0;
            if (accept) begin
              prev  <= cur;
              state <= RUN;
            end
          end
          RUN: begin
            if (accept) begin
              prev      <= cur;
              bit_out   <= dibit[1];
              lsb_q     <= dibit[0];
              bit_valid <= 1'b1;
              ser_lsb   <= 1'b0;
              idle_cnt  <= '0;
            end else if (msb_phase) begin
              bit_out <= lsb_q;
              ser_lsb <= 1'b1;
            end else if (lsb_phase) begin
              bit_valid <= 1'b0;
              ser_lsb   <= 1'b0;
            end else if (timeout) begin
              state    <= ACQ;
              idle_cnt <= '0;
            end else if (TMO_EN) begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
          default: state <= ACQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dqpsk_diff_decode.sv
// Directed bench for dqpsk_diff_decode with hand-computed bit streams and
// ready/valid/lock patterns per cycle.
module tb_dqpsk_diff_decode;

  logic       clk;
  logic       rst;
  logic       resync;
  logic       sym_valid;
  logic [1:0] sym_in;
  logic       sym_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       locked;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  seq [8];
  logic [31:0] rdy_v, vld_v, lck_v, bits_v;
  int          nbits;

  dqpsk_diff_decode #(.IDLE_TIMEOUT(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .resync    (resync),
    .sym_valid (sym_valid),
    .sym_in    (sym_in),
    .sym_ready (sym_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each cycle: sample outputs at negedge, then drive the next symbol.
  task automatic run_seq(input int n, input bit gated, input int cycles);
    int idx;
    idx    = 0;
    rdy_v  = '0;
    vld_v  = '0;
    lck_v  = '0;
    bits_v = '0;
    nbits  = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rdy_v = {rdy_v[30:0], sym_ready};
      vld_v = {vld_v[30:0], bit_valid};
      lck_v = {lck_v[30:0], locked};
      if (bit_valid) begin
        bits_v = {bits_v[30:0], bit_out};
        nbits++;
      end
      sym_valid = (idx < n) && (!gated || sym_ready);
      sym_in    = (idx < n) ? seq[idx] : 2'b00;
      if (sym_valid && sym_ready) idx++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    resync    = 1'b0;
    sym_valid = 1'b0;
    sym_in    = 2'b00;

    #1;
    chk("rst_ready", sym_ready, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_bit", bit_out, 0);

    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("release_ready_low", sym_ready, 0);
    @(negedge clk);
    chk("release_ready_high", sym_ready, 1);
    chk("release_unlocked", locked, 0);

    // basic decode: ref 00 then 01,11,11,10 -> 01 01 00 01
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b11; seq[4] = 2'b10;
    run_seq(5, 1'b1, 11);
    chk("basic_bits", bits_v, 32'h51);
    chk("basic_nbits", nbits, 8);
    chk("basic_vld", vld_v, 32'b00111111110);
    chk("basic_rdy", rdy_v, 32'b11010101011);
    chk("basic_lck", lck_v, 32'b01111111111);

    // idle timeout: 8 empty cycles counted, lock drops on the following edge
    run_seq(0, 1'b0, 9);
    chk("tmo_lck", lck_v, 32'b111111110);
    chk("tmo_vld", vld_v, 32'h0);

    // wrap-around: new ref 10 (phase 3), then 00 -> 01, 11 -> 11
    seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b11;
    run_seq(3, 1'b1, 7);
    chk("wrap_bits", bits_v, 32'b0111);
    chk("wrap_nbits", nbits, 4);
    chk("wrap_vld", vld_v, 32'b0011110);
    chk("wrap_lck", lck_v, 32'b0111111);

    // backpressure, sym_valid held: prev phase 2; 01,10,00,11,11 -> 10 11 01 11 00
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b00; seq[3] = 2'b11; seq[4] = 2'b11;
    run_seq(5, 1'b0, 12);
    chk("bp_bits", bits_v, 32'b1011011100);
    chk("bp_nbits", nbits, 10);
    chk("bp_rdy", rdy_v, 32'b101010101011);
    chk("bp_vld", vld_v, 32'b011111111110);

    // resync collision while LSB pending: 00 after phase 2 -> dibit 11
    @(negedge clk);
    sym_valid = 1'b1;
    sym_in    = 2'b00;
    @(negedge clk);
    chk("rs_msb_vld", bit_valid, 1);
    chk("rs_msb_bit", bit_out, 1);
    chk("rs_rdy_msb", sym_ready, 0);
    resync = 1'b1;
    sym_in = 2'b11;
    #1 chk("rs_rdy_resync", sym_ready, 1);
    @(negedge clk);
    chk("rs_flush", bit_valid, 0);
    chk("rs_lck", locked, 1);
    resync    = 1'b0;
    sym_valid = 1'b0;
    seq[0] = 2'b11;
    run_seq(1, 1'b1, 4);
    chk("rs_bits", bits_v, 32'b00);
    chk("rs_nbits", nbits, 2);
    chk("rs_vld", vld_v, 32'b0110);

    // async reset during MSB output
    @(negedge clk);
    sym_valid = 1'b1;
    sym_in    = 2'b01;
    @(negedge clk);
    sym_valid = 1'b0;
    chk("ar_msb_vld", bit_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_vld", bit_valid, 0);
    chk("ar_lck", locked, 0);
    chk("ar_rdy", sym_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    // ref 01 (phase 1), then 10 (phase 3) -> diff 2 -> 11
    seq[0] = 2'b01; seq[1] = 2'b10;
    run_seq(2, 1'b1, 5);
    chk("ar_bits", bits_v, 32'b11);
    chk("ar_nbits", nbits, 2);
    chk("ar_vld_seq", vld_v, 32'b00110);
    chk("ar_lck_seq", lck_v, 32'b01111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
